// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a framed program image over the UART byte
// stream, writes it word by word into instruction memory and keeps the core
// in reset until an image with a matching checksum has been loaded.
// Frame: SYNC, count lo, count hi, count*4 data bytes, 4 checksum bytes.
// Build option: define UART_BOOT_LOADER_TIMEOUT_EN to add the inter-byte
// timeout (err code 3); without it the loader waits forever for each byte.
module uart_boot_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          MAX_WORDS      = 512,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [31:0] load_inst_addr_o,
  output logic [31:0] load_inst_data_o,
  output logic        load_inst_w_enable_o,
  output logic [7:0]  ack_data_o,
  output logic        ack_valid_o,
  input  logic        ack_ready_i,
  output logic        core_hold_o,
  output logic        done_o,
  output logic [1:0]  err_code_o
);

  localparam logic [15:0] MAX_W16  = 16'(MAX_WORDS);
  localparam logic [7:0]  ACK_OK   = 8'h5A;
  localparam logic [7:0]  ACK_BAD  = 8'hEE;
`ifdef UART_BOOT_LOADER_TIMEOUT_EN
  localparam logic [7:0]  ACK_TO   = 8'hE7;
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, ACK, DONE} state_t;

  state_t      state;
  logic [15:0] count;
  logic [15:0] idx;
  logic [1:0]  byte_cnt;
  logic [23:0] shreg;   // upper three bytes collected so far (LSB-first)
  logic [31:0] sum;
`ifdef UART_BOOT_LOADER_TIMEOUT_EN
  logic [31:0] timer;
`endif

  // Word completed by the current byte: new byte lands in the MSB.
  logic [31:0] word;
  logic [15:0] len_in;
  assign word   = {rx_data_i, shreg};
  assign len_in = {rx_data_i, count[7:0]};

  // Frame parser, memory writer and ack handshake in one registered FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      count                <= '0;
      idx                  <= '0;
      byte_cnt             <= '0;
      shreg                <= '0;
      sum                  <= '0;
      load_inst_addr_o     <= '0;
      load_inst_data_o     <= '0;
      load_inst_w_enable_o <= 1'b0;
      ack_data_o           <= '0;
      ack_valid_o          <= 1'b0;
      core_hold_o          <= 1'b1;
      done_o               <= 1'b0;
      err_code_o           <= '0;
`ifdef UART_BOOT_LOADER_TIMEOUT_EN
      timer                <= '0;
`endif
    end else begin
      // Write strobe is a single-cycle pulse unless re-armed below.
      load_inst_w_enable_o <= 1'b0;

      case (state)
        IDLE: begin
          if (rx_valid_i && rx_data_i == SYNC_BYTE) begin
            state      <= LEN0;
            err_code_o <= 2'd0;
            sum        <= '0;
            idx        <= '0;
            byte_cnt   <= '0;
          end
        end

        LEN0: begin
          if (rx_valid_i) begin
            count[7:0] <= rx_data_i;
            state      <= LEN1;
          end
        end

        LEN1: begin
          if (rx_valid_i) begin
            count[15:8] <= rx_data_i;
            byte_cnt    <= '0;
            if (len_in > MAX_W16) begin
              err_code_o  <= 2'd2;
              ack_data_o  <= ACK_BAD;
              ack_valid_o <= 1'b1;
              state       <= ACK;
            end else if (len_in == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (rx_valid_i) begin
            shreg    <= word[31:8];
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              load_inst_w_enable_o <= 1'b1;
              load_inst_addr_o     <= BASE_ADDR + {14'd0, idx, 2'b00};
              load_inst_data_o     <= word;
              sum                  <= sum + word;
              idx                  <= idx + 16'd1;
              if (idx == count - 16'd1) state <= CSUM;
            end
          end
        end

        CSUM: begin
          if (rx_valid_i) begin
            shreg    <= word[31:8];
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              ack_valid_o <= 1'b1;
              state       <= ACK;
              if (word == sum) begin
                ack_data_o <= ACK_OK;
              end else begin
                ack_data_o <= ACK_BAD;
                err_code_o <= 2'd1;
              end
            end
          end
        end

        ACK: begin
          // rx bytes are dropped here; ack byte held until TX takes it.
          if (ack_ready_i) begin
            ack_valid_o <= 1'b0;
            if (ack_data_o == ACK_OK) begin
              state       <= DONE;
              core_hold_o <= 1'b0;
              done_o      <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end

        DONE: ;  // terminal until reset

        default: state <= IDLE;
      endcase

`ifdef UART_BOOT_LOADER_TIMEOUT_EN
      // Inter-byte watchdog; only fires on a cycle with no rx byte, so it
      // never collides with the byte handling above.
      if (state == LEN0 || state == LEN1 || state == DATA || state == CSUM) begin
        if (rx_valid_i) begin
          timer <= '0;
        end else if (timer == TO_LAST) begin
          timer       <= '0;
          err_code_o  <= 2'd3;
          ack_data_o  <= ACK_TO;
          ack_valid_o <= 1'b1;
          state       <= ACK;
        end else begin
          timer <= timer + 32'd1;
        end
      end else begin
        timer <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: frames built from word lists, expected writes,
// checksum and ack byte derived from the frame rules by a small model.
module tb_uart_boot_loader;

  localparam int          TO   = 200;
  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] load_inst_addr_o;
  logic [31:0] load_inst_data_o;
  logic        load_inst_w_enable_o;
  logic [7:0]  ack_data_o;
  logic        ack_valid_o;
  logic        ack_ready;
  logic        core_hold_o;
  logic        done_o;
  logic [1:0]  err_code_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] wq_a[$];
  logic [31:0] wq_d[$];

  uart_boot_loader #(
    .SYNC_BYTE(8'hA5), .MAX_WORDS(512), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .load_inst_addr_o(load_inst_addr_o), .load_inst_data_o(load_inst_data_o),
    .load_inst_w_enable_o(load_inst_w_enable_o),
    .ack_data_o(ack_data_o), .ack_valid_o(ack_valid_o), .ack_ready_i(ack_ready),
    .core_hold_o(core_hold_o), .done_o(done_o), .err_code_o(err_code_o)
  );

  always #5 clk = ~clk;

  // Record every memory write seen on the bus.
  always @(negedge clk)
    if (load_inst_w_enable_o === 1'b1) begin
      wq_a.push_back(load_inst_addr_o);
      wq_d.push_back(load_inst_data_o);
    end

  function automatic logic [31:0] sum_of(input logic [31:0] w[$]);
    logic [31:0] s = 32'h0;
    foreach (w[i]) s = s + w[i];
    return s;
  endfunction

  function automatic void build(input logic [31:0] w[$], input logic [15:0] cnt,
                                input logic [31:0] cs, output logic [7:0] bq[$]);
    bq = {};
    bq.push_back(8'hA5);
    bq.push_back(cnt[7:0]);
    bq.push_back(cnt[15:8]);
    foreach (w[i]) for (int k = 0; k < 4; k++) bq.push_back(w[i][8*k +: 8]);
    for (int k = 0; k < 4; k++) bq.push_back(cs[8*k +: 8]);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rx_valid = 1'b0; ack_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] bq[$], input bit gaps);
    int g;
    for (int i = 0; i < bq.size(); i++) begin
      @(negedge clk);
      rx_valid = 1'b1; rx_data = bq[i];
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      repeat (g) begin @(negedge clk); rx_valid = 1'b0; end
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic get_ack(output logic [7:0] b, output bit got);
    b = 8'h00; got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ack_valid_o === 1'b1) break;
      @(negedge clk);
    end
    if (ack_valid_o === 1'b1) begin
      b = ack_data_o; got = 1'b1;
      ack_ready = 1'b1;
      @(negedge clk);
      ack_ready = 1'b0;
    end
  endtask

  // Full frame: writes, ack byte, error code and hold/done against the model.
  task automatic run_frame(input string nm, input logic [31:0] w[$],
                           input logic [31:0] cs, input bit gaps);
    logic [7:0] bq[$];
    logic [7:0] ab;
    bit got, ok;
    ok = (cs == sum_of(w));
    wq_a.delete(); wq_d.delete();
    build(w, 16'(w.size()), cs, bq);
    send(bq, gaps);
    get_ack(ab, got);
    n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL %s ack_seen got %0d want 1", nm, got); end
    n_cmp++; if (ab !== (ok ? 8'h5A : 8'hEE)) begin n_err++; $display("FAIL %s ack_byte got %h want %h", nm, ab, ok ? 8'h5A : 8'hEE); end
    n_cmp++; if (wq_a.size() != w.size()) begin n_err++; $display("FAIL %s write_count got %0d want %0d", nm, wq_a.size(), w.size()); end
    for (int i = 0; i < w.size() && i < wq_a.size(); i++) begin
      n_cmp++; if (wq_a[i] !== BASE + 32'(4*i)) begin n_err++; $display("FAIL %s addr[%0d] got %h want %h", nm, i, wq_a[i], BASE + 32'(4*i)); end
      n_cmp++; if (wq_d[i] !== w[i]) begin n_err++; $display("FAIL %s data[%0d] got %h want %h", nm, i, wq_d[i], w[i]); end
    end
    n_cmp++; if (err_code_o !== (ok ? 2'd0 : 2'd1)) begin n_err++; $display("FAIL %s err got %0d want %0d", nm, err_code_o, ok ? 0 : 1); end
    n_cmp++; if (core_hold_o !== !ok) begin n_err++; $display("FAIL %s core_hold got %b want %b", nm, core_hold_o, !ok); end
    n_cmp++; if (done_o !== ok) begin n_err++; $display("FAIL %s done got %b want %b", nm, done_o, ok); end
    n_cmp++; if (ack_valid_o !== 1'b0) begin n_err++; $display("FAIL %s ack_valid_after got %b want 0", nm, ack_valid_o); end
  endtask

  task automatic test_reset(input string nm);
    n_cmp++; if (core_hold_o !== 1'b1) begin n_err++; $display("FAIL %s core_hold got %b want 1", nm, core_hold_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL %s done got %b want 0", nm, done_o); end
    n_cmp++; if (err_code_o !== 2'd0) begin n_err++; $display("FAIL %s err got %0d want 0", nm, err_code_o); end
    n_cmp++; if (ack_valid_o !== 1'b0) begin n_err++; $display("FAIL %s ack_valid got %b want 0", nm, ack_valid_o); end
    n_cmp++; if (ack_data_o !== 8'h00) begin n_err++; $display("FAIL %s ack_data got %h want 00", nm, ack_data_o); end
    n_cmp++; if (load_inst_w_enable_o !== 1'b0) begin n_err++; $display("FAIL %s wen got %b want 0", nm, load_inst_w_enable_o); end
    n_cmp++; if (load_inst_addr_o !== 32'h0 || load_inst_data_o !== 32'h0) begin n_err++; $display("FAIL %s addr/data got %h/%h want 0/0", nm, load_inst_addr_o, load_inst_data_o); end
  endtask

  // Known image; its word sum is 0xEFCFF233, so a zero checksum is rejected.
  task automatic test_bad_csum();
    logic [31:0] w[$];
    w = {32'h11223344, 32'hDEADBEEF};
    run_frame("bad_csum", w, 32'h0, 1'b0);
  endtask

  task automatic test_random_bad();
    logic [31:0] w[$];
    logic [7:0]  junk[$];
    logic [7:0]  j;
    for (int f = 0; f < 4; f++) begin
      w = {};
      repeat ($urandom_range(1, 8)) w.push_back($urandom);
      junk = {};
      repeat (2) begin j = 8'($urandom_range(0, 255)); if (j == 8'hA5) j = 8'h00; junk.push_back(j); end
      send(junk, 1'b1);   // noise in IDLE must be ignored
      run_frame($sformatf("rand_bad%0d", f), w, sum_of(w) ^ (32'h1 << $urandom_range(0, 31)), 1'b1);
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] w[$];
    w = {};
    run_frame("count0", w, 32'h0000_0100, 1'b0);
    repeat (512) w.push_back($urandom);
    run_frame("max_words", w, sum_of(w) + 32'h1, 1'b0);
  endtask

  task automatic test_len_err();
    logic [7:0] bq[$];
    logic [7:0] ab;
    bit got;
    wq_a.delete();
    bq = {8'hA5, 8'h01, 8'h02};   // count 513
    send(bq, 1'b0);
    get_ack(ab, got);
    n_cmp++; if (got !== 1'b1 || ab !== 8'hEE) begin n_err++; $display("FAIL len_err ack got %0d/%h want 1/ee", got, ab); end
    n_cmp++; if (err_code_o !== 2'd2) begin n_err++; $display("FAIL len_err err got %0d want 2", err_code_o); end
    n_cmp++; if (wq_a.size() != 0) begin n_err++; $display("FAIL len_err writes got %0d want 0", wq_a.size()); end
  endtask

  task automatic test_ack_stall();
    logic [7:0] bq[$];
    logic [7:0] sb[3];
    logic [15:0] cnt;
    logic [7:0] ab;
    bit got;
    int k;
    sb = '{8'hA5, 8'h02, 8'h00};
    cnt = 16'($urandom_range(513, 65535));
    wq_a.delete();
    bq = {8'hA5, cnt[7:0], cnt[15:8]};
    send(bq, 1'b0);
    k = 0;
    for (int c = 0; c < 10; c++) begin
      n_cmp++; if (ack_valid_o !== 1'b1 || ack_data_o !== 8'hEE) begin n_err++; $display("FAIL ack_stall c%0d got %b/%h want 1/ee", c, ack_valid_o, ack_data_o); end
      if (c == 1 || c == 4 || c == 7) begin rx_valid = 1'b1; rx_data = sb[k]; k++; end
      else rx_valid = 1'b0;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    get_ack(ab, got);
    n_cmp++; if (got !== 1'b1 || ab !== 8'hEE) begin n_err++; $display("FAIL ack_stall accept got %0d/%h want 1/ee", got, ab); end
    n_cmp++; if (err_code_o !== 2'd2 || wq_a.size() != 0) begin n_err++; $display("FAIL ack_stall err/writes got %0d/%0d want 2/0", err_code_o, wq_a.size()); end
  endtask

  task automatic test_timeout();
    logic [7:0] bq[$];
    int hits;
    wq_a.delete();
    bq = {8'hA5, 8'h01, 8'h00, 8'($urandom), 8'($urandom)};
    send(bq, 1'b0);
`ifdef UART_BOOT_LOADER_TIMEOUT_EN
    begin
      logic [7:0] ab;
      bit got;
      for (int i = 0; i < TO + 5; i++) begin
        if (ack_valid_o === 1'b1) break;
        @(negedge clk);
      end
      get_ack(ab, got);
      n_cmp++; if (got !== 1'b1 || ab !== 8'hE7) begin n_err++; $display("FAIL timeout ack got %0d/%h want 1/e7", got, ab); end
      n_cmp++; if (err_code_o !== 2'd3) begin n_err++; $display("FAIL timeout err got %0d want 3", err_code_o); end
      n_cmp++; if (core_hold_o !== 1'b1 || wq_a.size() != 0) begin n_err++; $display("FAIL timeout hold/writes got %b/%0d want 1/0", core_hold_o, wq_a.size()); end
    end
`else
    hits = 0;
    for (int i = 0; i < TO + 5; i++) begin
      if (ack_valid_o === 1'b1) hits++;
      @(negedge clk);
    end
    n_cmp++; if (hits != 0) begin n_err++; $display("FAIL no_timeout ack_cycles got %0d want 0", hits); end
    n_cmp++; if (err_code_o !== 2'd0 || wq_a.size() != 0) begin n_err++; $display("FAIL no_timeout err/writes got %0d/%0d want 0/0", err_code_o, wq_a.size()); end
    do_reset();
`endif
  endtask

  task automatic test_rst_mid_data();
    logic [31:0] w[$];
    logic [7:0]  bq[$];
    logic [7:0]  part[$];
    w = {$urandom, $urandom, $urandom, $urandom};
    build(w, 16'd4, sum_of(w), bq);
    part = bq[0:8];          // sync, count, 6 data bytes
    wq_a.delete();
    send(part, 1'b0);
    do_reset();
    test_reset("rst_mid");
    // Bad frame then good frame: error is set, then cleared by the next sync.
    w = {$urandom, $urandom, $urandom};
    run_frame("after_rst_bad", w, ~sum_of(w), 1'b1);
    w = {32'h11223344, 32'hDEADBEEF};
    run_frame("good_known", w, sum_of(w), 1'b1);
  endtask

  task automatic test_done_terminal();
    logic [31:0] w[$];
    logic [7:0]  bq[$];
    int hits;
    w = {$urandom};
    build(w, 16'd1, sum_of(w), bq);
    wq_a.delete();
    send(bq, 1'b0);
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      if (ack_valid_o === 1'b1) hits++;
      @(negedge clk);
    end
    n_cmp++; if (hits != 0 || wq_a.size() != 0) begin n_err++; $display("FAIL done_term ack/writes got %0d/%0d want 0/0", hits, wq_a.size()); end
    n_cmp++; if (done_o !== 1'b1 || core_hold_o !== 1'b0) begin n_err++; $display("FAIL done_term done/hold got %b/%b want 1/0", done_o, core_hold_o); end
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; ack_ready = 1'b0;
    do_reset();
    test_reset("reset");
    test_bad_csum();
    test_random_bad();
    test_boundaries();
    test_len_err();
    test_ack_stall();
    test_timeout();
    test_rst_mid_data();
    test_done_terminal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
